// File: rtl/pulse_burst_gen_pkg.sv
// Shared definitions for the pulse-count link (transmitter and count-to-N receiver).
package pulse_burst_gen_pkg;

  // Transmitter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } burst_state_t;

  // Terminal count both ends of the link agree on when no explicit length is given
  localparam int DEF_BURST_LEN = 100;

endpackage

// File: rtl/pulse_burst_gen_gap_timer.sv
// Loadable down-counter that times the low cycles between pulses.
module gap_timer
  import pulse_burst_gen_pkg::*;
#(
  parameter int GAP_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [GAP_W-1:0] loadVal,
  output logic             expire
);

  logic [GAP_W-1:0] count;

  // Load on request, otherwise count down while enabled and hold at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (en && (count != '0)) begin
      count <= count - GAP_W'(1);
    end
  end

  assign expire = en && (count == GAP_W'(1));

endmodule

// File: rtl/pulse_burst_gen.sv
// Pulse-count link transmitter: emits burstLen one-cycle pulses spaced by gapCycles, then done.
module pulse_burst_gen
  import pulse_burst_gen_pkg::*;
#(
  parameter int CNT_W   = 7,
  parameter int GAP_W   = 16,
  parameter int DEF_LEN = DEF_BURST_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             useDefault,
  input  logic [CNT_W-1:0] burstLen,
  input  logic [GAP_W-1:0] gapCycles,
  output logic             sigOut,
  output logic             busy,
  output logic             done
);

  burst_state_t     state;
  logic [CNT_W-1:0] remaining;
  logic [GAP_W-1:0] gapLen;
  logic [CNT_W-1:0] startLen;
  logic [GAP_W-1:0] startGap;
  logic             gapLoad;
  logic             gapEn;
  logic             gapExpire;

  // Effective length and spacing of a burst requested this cycle
  always_comb begin
    startLen = burstLen;
    if ((burstLen == '0) && useDefault) begin
      startLen = CNT_W'(DEF_LEN);
    end
    startGap = gapCycles;
    if (gapCycles == '0) begin
      startGap = GAP_W'(1);
    end
  end

  // The timer is only reloaded when a pulse is followed by another gap
  assign gapLoad = enable && (state == PULSE) && (remaining > CNT_W'(1));
  assign gapEn   = enable && (state == GAP);

  gap_timer #(
    .GAP_W(GAP_W)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (gapLoad),
    .en     (gapEn),
    .loadVal(gapLen),
    .expire (gapExpire)
  );

  // Burst sequencer; each transition sets the registered outputs of the state it enters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      gapLen    <= '0;
      sigOut    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (!enable) begin
      state  <= IDLE;
      sigOut <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sigOut <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
          if (start) begin
            remaining <= startLen;
            gapLen    <= startGap;
            if (startLen == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state  <= PULSE;
              sigOut <= 1'b1;
              busy   <= 1'b1;
            end
          end
        end
        PULSE: begin
          sigOut <= 1'b0;
          if (remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
          end
          if (remaining <= CNT_W'(1)) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= GAP;
            busy  <= 1'b1;
          end
        end
        GAP: begin
          if (gapExpire) begin
            state  <= PULSE;
            sigOut <= 1'b1;
          end
        end
        FIN: begin
          state  <= IDLE;
          sigOut <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          sigOut <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed scoreboard bench for pulse_burst_gen: per-cycle expected outputs are queued
// when a burst is launched and compared as the DUT produces them.
module tb_pulse_burst_gen;
  import pulse_burst_gen_pkg::*;

  localparam int CNT_W = 7;
  localparam int GAP_W = 16;

  typedef struct packed {
    logic sig;
    logic busy;
    logic done;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             start = 1'b0;
  logic             useDefault = 1'b0;
  logic [CNT_W-1:0] burstLen = '0;
  logic [GAP_W-1:0] gapCycles = '0;
  logic             sigOut;
  logic             busy;
  logic             done;

  vec_t expQ[$];
  int   assertCount = 0;
  int   failCount = 0;
  int   cycleIdx = 0;
  int   pulseCount = 0;
  int   rxFires = 0;

  pulse_burst_gen #(
    .CNT_W  (CNT_W),
    .GAP_W  (GAP_W),
    .DEF_LEN(DEF_BURST_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .start     (start),
    .useDefault(useDefault),
    .burstLen  (burstLen),
    .gapCycles (gapCycles),
    .sigOut    (sigOut),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic pushVec(input logic s, input logic b, input logic d);
    vec_t v;
    v.sig  = s;
    v.busy = b;
    v.done = d;
    expQ.push_back(v);
  endtask

  // Expected trace of a full burst from the cycle after the accepting edge, plus one idle cycle
  task automatic pushBurst(input int len, input int gap);
    int g;
    g = (gap == 0) ? 1 : gap;
    for (int k = 1; k <= len; k++) begin
      pushVec(1'b1, 1'b1, 1'b0);
      if (k < len) begin
        for (int j = 0; j < g; j++) pushVec(1'b0, 1'b1, 1'b0);
      end
    end
    pushVec(1'b0, 1'b0, 1'b1);
    pushVec(1'b0, 1'b0, 1'b0);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    assertCount++;
    assert (expQ.size() > 0) else begin
      failCount++;
      $error("[TB] FAIL %s.queue step %0d: got empty scoreboard, expected an entry", tag, cycleIdx);
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      assertCount++;
      assert (sigOut === e.sig) else begin
        failCount++;
        $error("[TB] FAIL %s.sigOut step %0d: got %b expected %b", tag, cycleIdx, sigOut, e.sig);
      end
      assertCount++;
      assert (busy === e.busy) else begin
        failCount++;
        $error("[TB] FAIL %s.busy step %0d: got %b expected %b", tag, cycleIdx, busy, e.busy);
      end
      assertCount++;
      assert (done === e.done) else begin
        failCount++;
        $error("[TB] FAIL %s.done step %0d: got %b expected %b", tag, cycleIdx, done, e.done);
      end
    end
    if (sigOut === 1'b1) begin
      pulseCount++;
      if (pulseCount == DEF_BURST_LEN) rxFires++;
    end
    cycleIdx++;
  endtask

  task automatic runChecks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      checkOutput(tag);
      stepCycle();
    end
  endtask

  // Present a start request for exactly one edge; returns at the first post-accept sample
  task automatic applyStimulus(input int len, input int gap, input logic useDef);
    burstLen   = CNT_W'(len);
    gapCycles  = GAP_W'(gap);
    useDefault = useDef;
    start      = 1'b1;
    stepCycle();
    start = 1'b0;
  endtask

  task automatic checkCount(input string tag, input int got, input int want);
    assertCount++;
    assert (got === want) else begin
      failCount++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  initial begin
    // Asynchronous reset from the start, held over a few edges
    #1 rst = 1'b0;
    #1;
    pushVec(1'b0, 1'b0, 1'b0);
    checkOutput("reset");
    stepCycle();
    pushVec(1'b0, 1'b0, 1'b0);
    pushVec(1'b0, 1'b0, 1'b0);
    runChecks(2, "resetHold");
    rst = 1'b1;

    // start with enable low is ignored
    start = 1'b1;
    for (int i = 0; i < 3; i++) pushVec(1'b0, 1'b0, 1'b0);
    runChecks(3, "noEnable");
    start  = 1'b0;
    enable = 1'b1;

    // 3 pulses, gap 2; start held during FIN must not launch another burst
    pulseCount = 0;
    pushBurst(3, 2);
    applyStimulus(3, 2, 1'b0);
    runChecks(7, "len3gap2");
    checkOutput("len3gap2.fin");
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    pushVec(1'b0, 1'b0, 1'b0);
    runChecks(2, "len3gap2.finStart");
    checkCount("len3gap2.pulses", pulseCount, 3);

    // Reset asserted in the middle of a gap
    pushBurst(5, 3);
    applyStimulus(5, 3, 1'b0);
    runChecks(2, "midReset");
    expQ.delete();
    #2 rst = 1'b0;
    #1;
    pushVec(1'b0, 1'b0, 1'b0);
    checkOutput("midReset.async");
    stepCycle();
    pushVec(1'b0, 1'b0, 1'b0);
    pushVec(1'b0, 1'b0, 1'b0);
    runChecks(2, "midReset.hold");
    rst = 1'b1;
    pushBurst(2, 1);
    applyStimulus(2, 1, 1'b0);
    runChecks(expQ.size(), "afterReset");

    // Empty burst without default
    pushBurst(0, 0);
    applyStimulus(0, 4, 1'b0);
    runChecks(expQ.size(), "empty");

    // Empty burst with default selected sends DEF_BURST_LEN pulses
    pulseCount = 0;
    rxFires    = 0;
    pushBurst(DEF_BURST_LEN, 0);
    applyStimulus(0, 0, 1'b1);
    runChecks(expQ.size(), "useDefault");
    checkCount("useDefault.pulses", pulseCount, DEF_BURST_LEN);
    useDefault = 1'b0;

    // Explicit 100 pulses, gap 0 into a count-to-100 receiver
    pulseCount = 0;
    rxFires    = 0;
    pushBurst(100, 0);
    applyStimulus(100, 0, 1'b0);
    runChecks(expQ.size(), "len100");
    checkCount("len100.pulses", pulseCount, 100);
    checkCount("len100.rxFires", rxFires, 1);

    // Abort after pulse 2 of 10, with a start re-pulsed while busy beforehand
    pulseCount = 0;
    pushBurst(10, 2);
    applyStimulus(10, 2, 1'b0);
    runChecks(1, "abort");
    start = 1'b1;
    runChecks(1, "abort.busyStart");
    start = 1'b0;
    runChecks(2, "abort");
    checkOutput("abort.lastGap");
    enable = 1'b0;
    expQ.delete();
    stepCycle();
    for (int i = 0; i < 4; i++) pushVec(1'b0, 1'b0, 1'b0);
    runChecks(4, "abort.idle");
    checkCount("abort.pulses", pulseCount, 2);
    enable = 1'b1;

    // Length and gap changed mid-burst have no effect
    pulseCount = 0;
    pushBurst(4, 1);
    applyStimulus(4, 1, 1'b0);
    runChecks(1, "latched");
    burstLen  = CNT_W'(9);
    gapCycles = GAP_W'(5);
    runChecks(expQ.size(), "latched");
    checkCount("latched.pulses", pulseCount, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
